sub_tc_32_32_seq: RTL and testbench
===================================

Name: sub_tc_32_32_seq

Overview:
- Multi-cycle two's-complement subtractor: computes Diff = A - B on WIDTH-bit signed operands and produces a WIDTH+1-bit signed result.
- Uses an internal carry-chained slice adder, processing SLICE bits per cycle as A + ~B + 1.
- Companion to the combinational add_tc adders in the FastAdder block.
- Wrapped in valid/ready handshakes on both the input and the result side, so it can sit between a stimulus source and a checker, or inside a datapath.

Parameters:
- WIDTH, 32, operand width in bits. Must be an integer multiple of SLICE.
- SLICE, 8, bits processed per CALC cycle. NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair A/B is valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend, signed two's complement.
- B  input  WIDTH  subtrahend, signed two's complement.
- out_valid  output  1  Diff/ovf are valid.
- out_ready  input  1  consumer accepts the result.
- Diff  output  WIDTH+1  A - B, sign-extended and exact.
- ovf  output  1  result does not fit in WIDTH bits: Diff[WIDTH] ^ Diff[WIDTH-1].

Behaviour:
- Reset:
  - rst_n is sampled low at a rising clk edge (synchronous, active-low).
  - On that edge: state=IDLE, out_valid=0, Diff=0, ovf=0, slice index=0, carry=0, internal operand and partial registers cleared.
  - in_ready = (state==IDLE) && rst_n, so in_ready is 0 while rst_n is low.
  - Reset mid-CALC or mid-DONE aborts the operation; no result is emitted.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch A and ~B, set carry=1, idx=0, go to CALC.
  - in_valid without acceptance (e.g. during reset) is ignored.
- CALC, one slice per cycle:
  - {carry, part[idx*SLICE +: SLICE]} = A[idx*SLICE +: SLICE] + nB[idx*SLICE +: SLICE] + carry.
  - Then idx increments.
  - On the last slice (idx==NSLICE-1), also compute the sign bit: part[WIDTH] = A[WIDTH-1] ^ nB[WIDTH-1] ^ carry_out_of_last_slice (sign-extension bit of the WIDTH+1 sum).
  - Load Diff and ovf from the final values on the same edge, set out_valid=1, go to DONE.
  - in_ready=0 throughout.
- Latency:
  - Operands are accepted at edge E0.
  - out_valid rises after edge E(NSLICE), i.e. edge E4 with defaults.
- DONE:
  - out_valid=1. Diff and ovf are held stable until out_ready=1.
  - On out_valid && out_ready: out_valid=0 at that edge, go to IDLE.
  - in_ready returns 1 the following cycle. Same-cycle accept in DONE is not allowed, so throughput is one result per NSLICE+2 cycles.
- Diff and ovf hold their last value when out_valid=0 and change only on CALC→DONE or reset. Consumers must qualify them with out_valid.
- out_ready is don't-care outside DONE. A and B are don't-care outside an accepting IDLE cycle, so changing them during CALC has no effect.
- Arithmetic:
  - The full WIDTH+1 result is exact for all inputs; no wrap.
  - Boundary case: -2^(WIDTH-1) - (2^(WIDTH-1)-1) = -(2^WIDTH)+1, which fits in WIDTH+1 bits.
- An elaboration error is required if WIDTH % SLICE != 0.

Test Plan:
- Simple subtract: A=5, B=3 → after 4 cycles out_valid=1, Diff=33'h0_0000_0002, ovf=0.
- Negative result: A=0, B=1 → Diff=33'h1_FFFF_FFFF (-1), ovf=0. Also A=0, B=0 → Diff=0, ovf=0.
- Positive overflow: A=32'h7FFF_FFFF, B=32'hFFFF_FFFF (-1) → Diff=33'h0_8000_0000, ovf=1.
- Negative overflow: A=32'h8000_0000, B=1 → Diff=33'h1_7FFF_FFFF, ovf=1. Also A=32'h8000_0000, B=32'h7FFF_FFFF → Diff=33'h1_0000_0001, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid rises; toggle A/B and in_valid meanwhile → Diff stable, in_ready=0, no second accept. After out_ready=1, out_valid drops and in_ready=1 the next cycle.
- Reset mid-CALC: assert rst_n=0 at the 2nd CALC edge → out_valid=0, Diff=0, state IDLE. After release, 10 random signed pairs (seeded $random) compared against a reference A-B in 33 bits → all match.

Source files
------------

// File: rtl/sub_tc_32_32_seq.sv
// Multi-cycle two's-complement subtractor: Diff = A - B (WIDTH+1 bits, exact),
// computed SLICE bits per cycle as A + ~B + 1, with valid/ready handshakes on both sides.
module sub_tc_32_32_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   Diff,
   output logic             ovf
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   generate
      if ((WIDTH % SLICE) != 0) begin : g_bad_slice
         $error("sub_tc_32_32_seq: WIDTH must be an integer multiple of SLICE");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    carry_q, carry_d;
   logic signed [WIDTH-1:0] a_q, a_d;
   logic signed [WIDTH-1:0] nb_q, nb_d;
   logic signed [WIDTH:0]   part_q, part_d;
   logic signed [WIDTH:0]   diff_q, diff_d;
   logic                    ovf_q, ovf_d;
   logic                    out_valid_q, out_valid_d;

   logic [SLICE-1:0]        a_slice;
   logic [SLICE-1:0]        nb_slice;
   logic [SLICE:0]          slice_sum;
   logic                    sign_bit;

   // One slice of the carry chain: returns {carry_out, sum}.
   function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y,
                                                input logic             cin);
      slice_add = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};
   endfunction

   // Sign-extension bit of the WIDTH+1 sum, from the operand MSBs and final carry.
   function automatic logic sign_ext(input logic a_msb,
                                     input logic nb_msb,
                                     input logic cout);
      sign_ext = a_msb ^ nb_msb ^ cout;
   endfunction

   assign in_ready  = (state_q == IDLE) && rst_n;
   assign out_valid = out_valid_q;
   assign Diff      = diff_q;
   assign ovf       = ovf_q;

   always_comb begin
      a_slice   = a_q[int'(idx_q)*SLICE +: SLICE];
      nb_slice  = nb_q[int'(idx_q)*SLICE +: SLICE];
      slice_sum = slice_add(a_slice, nb_slice, carry_q);
      sign_bit  = sign_ext(a_q[WIDTH-1], nb_q[WIDTH-1], slice_sum[SLICE]);
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      nb_d        = nb_q;
      part_d      = part_q;
      diff_d      = diff_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               a_d     = A;
               nb_d    = ~B;
               carry_d = 1'b1;
               idx_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            part_d[int'(idx_q)*SLICE +: SLICE] = slice_sum[SLICE-1:0];
            carry_d = slice_sum[SLICE];
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_W'(NSLICE - 1)) begin
               part_d[WIDTH] = sign_bit;
               diff_d        = part_d;
               ovf_d         = part_d[WIDTH] ^ part_d[WIDTH-1];
               out_valid_d   = 1'b1;
               idx_d         = '0;
               state_d       = DONE;
            end
         end
         DONE: begin
            // No same-cycle accept here: IDLE is re-entered first.
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         nb_q        <= '0;
         part_q      <= '0;
         diff_q      <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         nb_q        <= nb_d;
         part_q      <= part_d;
         diff_q      <= diff_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_sub_tc_32_32_seq.sv
// Directed bench for sub_tc_32_32_seq: hand-computed vectors, backpressure,
// mid-operation reset, and seeded random pairs against a 33-bit reference.
module tb_sub_tc_32_32_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [32:0] Diff;
   logic        ovf;

   int n_tests = 0;
   int n_fail  = 0;

   sub_tc_32_32_seq #(.WIDTH(32), .SLICE(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Diff      (Diff),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Issue one operation, wait for the result, check it, and leave it pending in DONE.
   task automatic issue_and_wait(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic [32:0] exp_diff, input logic exp_ovf);
      int cycles;
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      A        = a;
      B        = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      A        = ~a;
      B        = ~b;
      cycles   = 0;
      while (!out_valid && cycles < 20) begin
         check({tag, "_busy"}, 64'(in_ready), 64'd0);
         step();
         cycles++;
      end
      check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_latency"}, 64'(cycles), 64'd4);
      check({tag, "_diff"}, 64'(Diff), 64'(exp_diff));
      check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_drop"}, 64'(out_valid), 64'd0);
      check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [32:0] exp_diff, input logic exp_ovf);
      issue_and_wait(tag, a, b, exp_diff, exp_ovf);
      drain(tag);
   endtask

   initial begin
      logic [32:0] held;
      logic [32:0] ref_d;
      logic [31:0] ra, rb;
      integer      seed;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      repeat (2) step();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_diff", 64'(Diff), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      rst_n = 1'b1;
      step();

      run_op("sub_5_3",      32'd5,          32'd3,          33'h0_0000_0002, 1'b0);
      run_op("sub_0_1",      32'd0,          32'd1,          33'h1_FFFF_FFFF, 1'b0);
      run_op("sub_0_0",      32'd0,          32'd0,          33'h0_0000_0000, 1'b0);
      run_op("pos_ovf",      32'h7FFF_FFFF,  32'hFFFF_FFFF,  33'h0_8000_0000, 1'b1);
      run_op("neg_ovf",      32'h8000_0000,  32'h0000_0001,  33'h1_7FFF_FFFF, 1'b1);
      run_op("min_minus_max",32'h8000_0000,  32'h7FFF_FFFF,  33'h1_0000_0001, 1'b1);
      run_op("sub_m3_m5",    32'hFFFF_FFFD,  32'hFFFF_FFFB,  33'h0_0000_0002, 1'b0);
      run_op("carry_chain",  32'h0001_0000,  32'h0000_0001,  33'h0_0000_FFFF, 1'b0);

      // Backpressure: result must hold while new operands are offered.
      issue_and_wait("bp", 32'd100, 32'd58, 33'h0_0000_002A, 1'b0);
      held = Diff;
      for (int i = 0; i < 3; i++) begin
         A        = 32'h1234_5678 + i;
         B        = 32'h0000_0010 * i;
         in_valid = 1'b1;
         step();
         check("bp_hold_valid", 64'(out_valid), 64'd1);
         check("bp_hold_diff", 64'(Diff), 64'(held));
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      drain("bp");
      repeat (3) step();
      check("bp_no_second", 64'(out_valid), 64'd0);

      // Reset sampled at the 2nd CALC edge aborts the operation.
      A        = 32'd9;
      B        = 32'd4;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_diff", 64'(Diff), 64'd0);
      check("abort_ovf", 64'(ovf), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b1;
      step();
      check("abort_idle", 64'(in_ready), 64'd1);
      repeat (6) step();
      check("abort_no_result", 64'(out_valid), 64'd0);

      seed = 32'h5EED_1234;
      for (int i = 0; i < 10; i++) begin
         ra    = $random(seed);
         rb    = $random(seed);
         ref_d = {ra[31], ra} - {rb[31], rb};
         run_op($sformatf("rand%0d", i), ra, rb, ref_d, ref_d[32] ^ ref_d[31]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
